// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB 1.x transmit line encoder.
// Line states, per-period classification and the NRZI flip helper.
package usb_tx_pkg;

    typedef enum logic [1:0] {
        LS_J   = 2'd0,
        LS_K   = 2'd1,
        LS_SE0 = 2'd2
    } line_state_t;

    typedef enum logic [1:0] {
        PT_DATA  = 2'd0,
        PT_STUFF = 2'd1,
        PT_EOP   = 2'd2,
        PT_IDLE  = 2'd3
    } period_t;

    localparam int STUFF_LIMIT          = 6;
    localparam int DEFAULT_CLKS_PER_BIT = 8;
    localparam logic [3:0] BYTE_BITS    = 4'd8;

    function automatic line_state_t nrzi_flip(input line_state_t ls);
        return (ls == LS_J) ? LS_K : LS_J;
    endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer: counts clk cycles within one USB bit period and
// produces the bit_start / bit_done strobes for the line encoder.
module tx_bit_timer
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       timer_en,
    input  logic       timer_clr,
    output logic [3:0] pd_count,
    output logic       bit_start,
    output logic       bit_done
);

    localparam logic [3:0] PD_LAST = 4'(CLKS_PER_BIT - 1);

    logic [3:0] pd_count_q, pd_count_d;

    always_comb begin
        pd_count_d = pd_count_q;
        if (timer_clr) begin
            pd_count_d = '0;
        end else if (timer_en) begin
            pd_count_d = (pd_count_q == PD_LAST) ? 4'd0 : pd_count_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pd_count_q <= '0;
        end else begin
            pd_count_q <= pd_count_d;
        end
    end

    assign pd_count  = pd_count_q;
    assign bit_start = timer_en && (pd_count_q == 4'd0);
    assign bit_done  = timer_en && !timer_clr && (pd_count_q == PD_LAST);

endmodule

// File: rtl/tx_line_encoder.sv
// USB 1.x transmit serialiser: LSB-first shifter, NRZI, EOP (SE0) drive.
// Bit stuffing is built only when TX_BIT_STUFF_EN is defined.
//
// period_q | meaning
// PT_DATA  | current period carries a data bit; shifts on bit_done
// PT_STUFF | inserted stuff bit; no shift, no count on bit_done
// PT_EOP   | SE0 period; shifter and bit count frozen
// PT_IDLE  | J period following SE0; shifter and bit count frozen
module tx_line_encoder
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       timer_en,
    input  logic       timer_clr,
    input  logic       load_en,
    input  logic [7:0] data_to_send,
    input  logic       send_eop,
    output logic       dp_out,
    output logic       dm_out,
    output logic       bit_done,
    output logic       byte_done,
    output logic [3:0] pd_count,
    output logic [3:0] bit_count,
    output logic       stuff_bit
);

    logic        bit_start;
    logic        stuff_now;
    logic        data_period_done;
    line_state_t line_q, line_d;
    line_state_t nrzi_q, nrzi_d;
    period_t     period_q, period_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [3:0]  bit_count_q, bit_count_d;

    tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk       (clk),
        .n_rst     (n_rst),
        .timer_en  (timer_en),
        .timer_clr (timer_clr),
        .pd_count  (pd_count),
        .bit_start (bit_start),
        .bit_done  (bit_done)
    );

    assign data_period_done = bit_done && (period_q == PT_DATA);

`ifdef TX_BIT_STUFF_EN
    logic [2:0] ones_q, ones_d;

    assign stuff_now = (ones_q == 3'(STUFF_LIMIT));

    always_comb begin
        ones_d = ones_q;
        if (bit_start) begin
            if (send_eop || line_q == LS_SE0) begin
                ones_d = '0;
            end else if (!stuff_now) begin
                ones_d = shreg_q[0] ? ones_q + 3'd1 : 3'd0;
            end
        end
        if (bit_done && period_q == PT_STUFF) begin
            ones_d = '0;
        end
        if (timer_clr) begin
            ones_d = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ones_q <= '0;
        end else begin
            ones_q <= ones_d;
        end
    end
`else
    assign stuff_now = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            line_q      <= LS_J;
            nrzi_q      <= LS_J;
            period_q    <= PT_IDLE;
            shreg_q     <= 8'hFF;
            bit_count_q <= '0;
        end else begin
            line_q      <= line_d;
            nrzi_q      <= nrzi_d;
            period_q    <= period_d;
            shreg_q     <= shreg_d;
            bit_count_q <= bit_count_d;
        end
    end

    always_comb begin
        line_d      = line_q;
        nrzi_d      = nrzi_q;
        period_d    = period_q;
        shreg_d     = shreg_q;
        bit_count_d = bit_count_q;

        if (bit_start) begin
            if (send_eop) begin
                line_d   = LS_SE0;
                nrzi_d   = LS_J;
                period_d = PT_EOP;
            end else if (line_q == LS_SE0) begin
                line_d   = LS_J;
                nrzi_d   = LS_J;
                period_d = PT_IDLE;
            end else if (stuff_now) begin
                nrzi_d   = nrzi_flip(nrzi_q);
                line_d   = nrzi_d;
                period_d = PT_STUFF;
            end else begin
                nrzi_d   = shreg_q[0] ? nrzi_q : nrzi_flip(nrzi_q);
                line_d   = nrzi_d;
                period_d = PT_DATA;
            end
        end

        if (data_period_done) begin
            shreg_d = {1'b1, shreg_q[7:1]};
            if (bit_count_q != BYTE_BITS) begin
                bit_count_d = bit_count_q + 4'd1;
            end
        end

        // A load landing on the final bit_done of a byte takes priority
        if (load_en) begin
            shreg_d     = data_to_send;
            bit_count_d = '0;
        end
        if (timer_clr) begin
            bit_count_d = '0;
        end
    end

    always_comb begin
        dp_out = 1'b1;
        dm_out = 1'b0;
        case (line_q)
            LS_K: begin
                dp_out = 1'b0;
                dm_out = 1'b1;
            end
            LS_SE0: begin
                dp_out = 1'b0;
                dm_out = 1'b0;
            end
            default: begin
                dp_out = 1'b1;
                dm_out = 1'b0;
            end
        endcase
        byte_done = data_period_done && (bit_count_q == BYTE_BITS - 4'd1);
`ifdef TX_BIT_STUFF_EN
        stuff_bit = (period_q == PT_STUFF);
`else
        stuff_bit = 1'b0;
`endif
    end

    assign bit_count = bit_count_q;

endmodule
